// File: rtl/display_scan_ctrl_pkg.sv
// rtl/display_scan_ctrl_pkg.sv - shared types, segment constants and BCD encoder for the display scan controller
package display_scan_ctrl_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [1:0] DP_IDX  = 2'd2;

    // Active-high gfedcba patterns; inverted on the way to the pins
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - time inputs and display pin bundle between clock logic and scan controller
interface display_scan_if;
    logic [15:0] time_a;
    logic [15:0] time_b;
    logic        sel_b;
    logic        alarm;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output time_a, time_b, sel_b, alarm,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  time_a, time_b, sel_b, alarm,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl_seg7_lut.sv
// rtl/display_scan_ctrl_seg7_lut.sv - nibble to active-low segments with invalid-BCD and leading-zero blanking
module seg7_lut
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       zero_blank,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = ~bcd_to_seg(nibble);
        if (zero_blank && (nibble == 4'd0)) begin
            seg_n = SEG_OFF;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit 7-seg scan controller with per-frame snapshot; DISP_BLINK_EN adds alarm blink
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          CE,
    display_scan_if.slave dif
);

    localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;
    logic [3:0]    nibble;
    logic [6:0]    lut_seg;
    logic          blink_off;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        frame_done_d = 1'b0;
        if (CE) begin
            if (state_q == ST_BLANK) begin
                // First CE cycle of a frame latches the time so one frame never mixes values
                if ((idx_q == 2'd0) && (cnt_q == '0)) begin
                    shadow_d = dif.sel_b ? dif.time_b : dif.time_a;
                end
                if (cnt_q == CW'(BLANK_CYC - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == CW'(DIV - 1)) begin
                    state_d      = ST_BLANK;
                    cnt_d        = '0;
                    idx_d        = idx_q + 2'd1;
                    frame_done_d = (idx_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef DISP_BLINK_EN
    logic [5:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_done_d) begin
            frame_cnt_d = frame_cnt_q + 6'd1;
        end
        blink_off = dif.alarm && frame_cnt_d[5];
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            frame_cnt_q <= 6'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    logic unused_alarm;
    assign unused_alarm = dif.alarm;
    assign blink_off    = 1'b0;
`endif

    assign nibble = 4'(shadow_d >> {idx_d, 2'b00});

    seg7_lut u_seg7_lut (
        .nibble     (nibble),
        .zero_blank (idx_d == 2'd3),
        .seg_n      (lut_seg)
    );

    // Outputs are computed from next state so they move on the same edge as the FSM
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (CE) begin
            an_d  = 4'hF;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
            if ((state_d == ST_SHOW) && !blink_off) begin
                an_d  = ~(4'b0001 << idx_d);
                seg_d = lut_seg;
                dp_d  = (idx_d != DP_IDX);
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q      <= ST_BLANK;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            shadow_q     <= 16'h0000;
            an_q         <= 4'hF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dif.an         = an_q;
    assign dif.seg        = seg_q;
    assign dif.dp         = dp_q;
    assign dif.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl against a frame-position reference model
module tb_display_scan_ctrl;

    localparam int D = 4;
    localparam int B = 2;
    localparam int P = B + D;
    localparam int F = 4 * P;

    logic clk = 1'b0;
    logic clr;
    logic ce;

    always #5 clk = ~clk;

    display_scan_if dif ();

    display_scan_ctrl #(.DIV(D), .BLANK_CYC(B)) dut (
        .CLK (clk),
        .CLR (clr),
        .CE  (ce),
        .dif (dif)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } obs_t;

    obs_t expq[$];
    obs_t cur;
    int   checks = 0;
    int   errors = 0;
    int   n;
    logic [15:0] sh;
    logic [6:0]  enc_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // n = CE edges since reset; frame position, digit and phase follow by division
    task automatic model_step();
        int p, d, r;
        logic [3:0] nib;
        logic off;
        if (clr) begin
            n   = 0;
            sh  = 16'h0000;
            cur = '{4'hF, 7'h7F, 1'b1, 1'b0};
            return;
        end
        if (!ce) begin
            cur.fd = 1'b0;
            return;
        end
        if ((n % F) == 0) sh = dif.sel_b ? dif.time_b : dif.time_a;
        n++;
        p = n % F;
        d = p / P;
        r = p % P;
        cur.fd = (p == 0);
        off = 1'b0;
`ifdef DISP_BLINK_EN
        off = dif.alarm && (((n / F) % 64) >= 32);
`endif
        if ((r >= B) && !off) begin
            nib    = sh[4*d +: 4];
            cur.an = 4'hF & ~(4'd1 << d);
            cur.seg = ((nib > 4'd9) || ((d == 3) && (nib == 4'd0))) ? 7'h7F : ~enc_tab[nib];
            cur.dp  = (d != 2);
        end else begin
            cur.an  = 4'hF;
            cur.seg = 7'h7F;
            cur.dp  = 1'b1;
        end
    endtask

    task automatic cycle();
        model_step();
        expq.push_back(cur);
        @(negedge clk);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic run_to_pos(input int pos);
        int guard = 0;
        while (((n % F) != pos) && (guard < 4 * F)) begin
            cycle();
            guard++;
        end
        chk("reach_frame_pos", 16'((n % F) == pos), 16'd1);
    endtask

    task automatic async_clear();
        clr = 1'b1;
        #1;
        chk("async_clr_an", dif.an, 4'hF);
        chk("async_clr_seg", dif.seg, 7'h7F);
        chk("async_clr_dp", dif.dp, 1'b1);
        chk("async_clr_fd", dif.frame_done, 1'b0);
        cycle();
        cycle();
        clr = 1'b0;
    endtask

    function automatic logic [15:0] rnd_time();
        logic [15:0] t;
        for (int i = 0; i < 4; i++) t[4*i +: 4] = 4'($urandom_range(0, 11));
        return t;
    endfunction

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("an", dif.an, e.an);
                chk("seg", dif.seg, e.seg);
                chk("dp", dif.dp, e.dp);
                chk("frame_done", dif.frame_done, e.fd);
            end
        end
    end

    initial begin : stimulus
        clr = 1'b1;
        ce  = 1'b1;
        dif.time_a = 16'h1234;
        dif.time_b = 16'h0507;
        dif.sel_b  = 1'b0;
        dif.alarm  = 1'b0;
        n  = 0;
        sh = 16'h0000;
        @(negedge clk);
        chk("reset_an", dif.an, 4'hF);
        chk("reset_seg", dif.seg, 7'h7F);
        run(3);
        clr = 1'b0;
        run(2 * F);

        run_to_pos(P + B + 1);
        dif.sel_b = 1'b1;
        run(2 * F);

        dif.sel_b  = 1'b0;
        dif.time_a = 16'h0A0F;
        run(2 * F);

        run_to_pos(P + B + 1);
        ce = 1'b0;
        run(10);
        ce = 1'b1;
        run(F);

        async_clear();
        run(F);
        run_to_pos(2 * P + 1);
        async_clear();

        dif.alarm = 1'b1;
        for (int i = 0; i < 3500; i++) begin
            ce = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) dif.time_a = rnd_time();
            if ($urandom_range(0, 39) == 0) dif.time_b = rnd_time();
            if ($urandom_range(0, 29) == 0) dif.sel_b = ~dif.sel_b;
            if ($urandom_range(0, 599) == 0) dif.alarm = ~dif.alarm;
            cycle();
        end
        ce = 1'b1;

        @(posedge clk);
        #2;
        chk("queue_drained", 16'(expq.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
